inst_fetch_pq: RTL and testbench

Parametrised RV32I instruction-fetch unit with a prefetch queue and branch redirect. It issues single-beat AXI4 reads ahead of the decoder and tracks up to MAX_OUTSTANDING in-flight requests. Returned words go into a DEPTH-entry FIFO of {pc, inst}. On redirect it flushes the queue and discards stale responses. Sits between the core's decode stage and the instruction-side AXI interconnect.

---
 rtl/inst_fetch_pq_pkg.sv | 23 ++
 rtl/inst_fetch_pq_if.sv | 29 ++
 rtl/inst_fetch_pq_fifo.sv | 56 +++++
 rtl/inst_fetch_pq.sv | 150 +++++++++++++++
 tb/tb_inst_fetch_pq.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pq_pkg.sv
// Shared AXI constants, the prefetch entry type and a constant-foldable log2
// helper for the instruction fetch unit.
package ifetch_pkg;

  localparam logic [2:0] ARSIZE_4B  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_pq_if.sv
// Single-beat AXI4 read channel (AR + R) between the fetch unit and the
// instruction-side interconnect.
interface inst_fetch_pq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [7:0]        M_AXI_ARLEN;
  logic [2:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    output M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    input  M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/inst_fetch_pq_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH need not be a power
// of two. The storage array is not reset, only the pointers and count.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [clog2(DEPTH):0]   count,
  output logic                    empty
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_pq.sv
// RV32I prefetching instruction fetch with branch redirect and stale-beat discard.
// Build option: IFETCH_ZERO_SQUASH_EN drops all-zero instruction words instead of queueing them.
module inst_fetch_pq
  import ifetch_pkg::*;
#(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC           = 32'h2000_0000,
  parameter int          DEPTH              = 4,
  parameter int          MAX_OUTSTANDING    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EXEC,
  input  logic                  STALL,
  input  logic                  REDIRECT,
  input  logic [31:0]           REDIRECT_PC,
  output logic [31:0]           I_PC,
  output logic [31:0]           I_INST,
  output logic                  I_VALID,
  output logic                  MEM_WAIT,
  output logic                  FETCH_ERR,
  inst_fetch_pq_if.master       m_axi
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam int IW = clog2(MAX_OUTSTANDING) + 1;
  // Headroom for stale beats piling up across back-to-back redirects.
  localparam int DW = IW + 4;

  logic [31:0]   fetch_pc;
  logic [31:0]   ar_pc;
  logic          arvalid;
  logic          ar_stale;
  logic [DW-1:0] discard;
  logic          fetch_err;

  logic          ar_hs;
  logic          r_hs;
  logic          r_live;
  logic          squash;
  logic          issue;
  logic          push_data;
  logic          pop_data;
  logic          tag_push;
  logic [DW-1:0] disc_add;
  logic          disc_sub;

  logic [CW-1:0] data_count;
  logic          data_empty;
  logic [IW-1:0] inflight;
  logic          tag_empty;
  logic [31:0]   tag_pc;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign ar_hs  = arvalid && m_axi.M_AXI_ARREADY;
  assign r_hs   = m_axi.M_AXI_RVALID;
  // A beat is live only once every stale beat ahead of it has been dropped.
  assign r_live = r_hs && (discard == '0) && !REDIRECT;

`ifdef IFETCH_ZERO_SQUASH_EN
  assign squash = (m_axi.M_AXI_RDATA[31:0] == 32'h0);
`else
  assign squash = 1'b0;
`endif

  // A pending-but-unaccepted AR counts against credit so back-to-back issue cannot overrun.
  assign issue = EXEC && !REDIRECT && (!arvalid || m_axi.M_AXI_ARREADY) &&
                 (int'(inflight) + int'(arvalid) < MAX_OUTSTANDING) &&
                 (int'(data_count) + int'(inflight) + int'(arvalid) < DEPTH);

  assign tag_push   = ar_hs && !REDIRECT && !ar_stale;
  assign push_data  = r_live && !squash;
  assign pop_data   = !data_empty && !STALL;
  assign push_entry = '{pc: tag_pc, inst: m_axi.M_AXI_RDATA[31:0]};

  always_comb begin
    disc_add = '0;
    if (REDIRECT)              disc_add = DW'(inflight) + DW'(ar_hs);
    else if (ar_hs && ar_stale) disc_add = DW'(1);
    disc_sub = r_hs && (REDIRECT || discard != '0);
  end

  // Request side: fetch_pc always names the next word not yet requested.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc <= RESET_PC;
      arvalid  <= 1'b0;
      ar_stale <= 1'b0;
      discard  <= '0;
    end else begin
      if (REDIRECT)   fetch_pc <= REDIRECT_PC & ~32'h3;
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (issue)      arvalid <= 1'b1;
      else if (ar_hs) arvalid <= 1'b0;
      if (REDIRECT)   ar_stale <= arvalid && !ar_hs;
      else if (ar_hs) ar_stale <= 1'b0;
      discard <= discard + disc_add - DW'(disc_sub);
    end
  end

  always_ff @(posedge CLK) begin
    if (issue) ar_pc <= fetch_pc;
  end

  always_ff @(posedge CLK) begin
    if (RST || REDIRECT)                               fetch_err <= 1'b0;
    else if (r_live && m_axi.M_AXI_RRESP != RESP_OKAY) fetch_err <= 1'b1;
  end

  // Tag queue occupancy doubles as the live in-flight count.
  ifetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk   (CLK),
    .rst   (RST),
    .flush (REDIRECT),
    .push  (tag_push),
    .pop   (r_live),
    .din   (ar_pc),
    .dout  (tag_pc),
    .count (inflight),
    .empty (tag_empty)
  );

  ifetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
    .clk   (CLK),
    .rst   (RST),
    .flush (REDIRECT),
    .push  (push_data),
    .pop   (pop_data),
    .din   (push_entry),
    .dout  (head),
    .count (data_count),
    .empty (data_empty)
  );

  assign I_VALID   = !data_empty;
  assign I_PC      = I_VALID ? head.pc : 32'h0;
  assign I_INST    = I_VALID ? head.inst : 32'h0;
  assign MEM_WAIT  = data_empty && (!tag_empty || discard != '0);
  assign FETCH_ERR = fetch_err;

  assign m_axi.M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(ar_pc);
  assign m_axi.M_AXI_ARLEN   = 8'd0;
  assign m_axi.M_AXI_ARSIZE  = ARSIZE_4B;
  assign m_axi.M_AXI_ARBURST = BURST_INCR;
  assign m_axi.M_AXI_ARVALID = arvalid;
  assign m_axi.M_AXI_RREADY  = 1'b1;

endmodule

// File: tb/tb_inst_fetch_pq.sv
// Scoreboard bench for inst_fetch_pq: a randomized in-order AXI slave, an
// expected instruction stream rebuilt at every (re)start, and decoupled monitors.
`timescale 1ns/1ps
module tb_inst_fetch_pq;

  localparam logic [31:0] RESET_PC = 32'h2000_0000;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EXEC = 1'b0;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic [31:0] I_PC;
  logic [31:0] I_INST;
  logic        I_VALID;
  logic        MEM_WAIT;
  logic        FETCH_ERR;

  inst_fetch_pq_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  inst_fetch_pq #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .RESET_PC(RESET_PC),
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .CLK(CLK), .RST(RST), .EXEC(EXEC), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID),
    .MEM_WAIT(MEM_WAIT), .FETCH_ERR(FETCH_ERR), .m_axi(axi)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory image: every word is nonzero except the deliberate hole at 0x20000008.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h2000_0008) return 32'h0;
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]} | 32'h1;
  endfunction

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t exp_q[$];

  // Expected program-order stream from a start PC, as the decoder should see it.
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_t e;
      e.pc   = pc + 32'(4 * i);
      e.inst = memfn(e.pc);
`ifdef IFETCH_ZERO_SQUASH_EN
      if (e.inst == 32'h0) continue;
`endif
      exp_q.push_back(e);
    end
  endtask

  typedef struct { logic [31:0] addr; int rdy; } beat_t;
  beat_t       r_q[$];
  logic [31:0] ar_log[$];
  logic [31:0] err_addr = 32'h1;
  int          cyc = 0;
  int          ar_cnt = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  int          ardy_pct = 100;

  // In-order AXI slave; handshakes sampled at negedge, effects applied after the edge.
  initial begin
    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID  = 1'b0;
    axi.M_AXI_RDATA   = 32'h0;
    axi.M_AXI_RRESP   = 2'b00;
    forever begin
      logic s_ar, s_r, s_rst;
      logic [31:0] s_a;
      @(negedge CLK);
      s_ar  = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
      s_r   = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
      s_a   = axi.M_AXI_ARADDR;
      s_rst = RST;
      @(posedge CLK);
      #1;
      cyc++;
      if (s_rst) begin
        r_q.delete();
      end else begin
        if (s_r && r_q.size() > 0) void'(r_q.pop_front());
        if (s_ar) begin
          beat_t b;
          b.addr = s_a;
          b.rdy  = cyc + int'($urandom_range(lat_max, lat_min));
          r_q.push_back(b);
          ar_cnt++;
          ar_log.push_back(s_a);
        end
      end
      axi.M_AXI_ARREADY = ($urandom_range(99, 0) < ardy_pct);
      if (r_q.size() > 0 && r_q[0].rdy <= cyc) begin
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RDATA  = memfn(r_q[0].addr);
        axi.M_AXI_RRESP  = (r_q[0].addr == err_addr) ? 2'b10 : 2'b00;
      end else begin
        axi.M_AXI_RVALID = 1'b0;
      end
    end
  end

  // Output monitor: every consumed head entry must be the next expected word.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && !REDIRECT && I_VALID && !STALL) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_unexpected: got pc %h with no entry expected", I_PC);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_pc", I_PC, e.pc);
          check("out_inst", I_INST, e.inst);
        end
      end
    end
  end

  // AR must hold valid and address until accepted.
  initial begin
    logic pend;
    logic [31:0] pa;
    pend = 1'b0;
    pa   = 32'h0;
    forever begin
      @(negedge CLK);
      if (pend) begin
        check("arvalid_hold", {31'h0, axi.M_AXI_ARVALID}, 32'h1);
        check("araddr_hold", axi.M_AXI_ARADDR, pa);
      end
      pend = axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY && !RST;
      pa   = axi.M_AXI_ARADDR;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    RST = 1'b1;
    err_addr = RESET_PC + 32'd8;
    lat_min = 0; lat_max = 0; ardy_pct = 100;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ivalid",  {31'h0, I_VALID}, 32'h0);
    check("rst_ipc",     I_PC, 32'h0);
    check("rst_iinst",   I_INST, 32'h0);
    check("rst_arvalid", {31'h0, axi.M_AXI_ARVALID}, 32'h0);
    check("rst_err",     {31'h0, FETCH_ERR}, 32'h0);
    check("rst_memwait", {31'h0, MEM_WAIT}, 32'h0);
    check("ar_consts", {21'h0, axi.M_AXI_ARLEN, axi.M_AXI_ARSIZE},
          {21'h0, 8'h00, 3'b010});
    check("ar_burst_rready", {29'h0, axi.M_AXI_ARBURST, axi.M_AXI_RREADY}, {29'h0, 2'b01, 1'b1});

    // Zero-wait slave, consumer stalled: queue fills to exactly DEPTH.
    @(posedge CLK); #2;
    RST = 1'b0; EXEC = 1'b1; STALL = 1'b1;
    ar_cnt = 0; ar_log.delete();
    restart(RESET_PC);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge CLK);
      if (axi.M_AXI_RVALID) hit = 1'b1;
    end
    check("first_rvalid_seen", {31'h0, hit}, 32'h1);
    @(negedge CLK);
    check("r_to_out_valid", {31'h0, I_VALID}, 32'h1);
    check("r_to_out_pc", I_PC, RESET_PC);
    repeat (17) @(negedge CLK);
    check("stall_ar_count", ar_cnt, DEPTH);
    for (int i = 0; i < DEPTH && i < ar_log.size(); i++)
      check("araddr_seq", ar_log[i], RESET_PC + 32'(4 * i));
    check("stall_no_arvalid", {31'h0, axi.M_AXI_ARVALID}, 32'h0);
    check("stall_head_pc", I_PC, RESET_PC);
    check("err_set", {31'h0, FETCH_ERR}, 32'h1);

    @(posedge CLK); #2;
    STALL = 1'b0;
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    check("err_sticky", {31'h0, FETCH_ERR}, 32'h1);

    // Redirect with two requests in flight and slow responses.
    lat_min = 5; lat_max = 5;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge CLK);
      if (r_q.size() == 2) hit = 1'b1;
    end
    check("two_inflight_seen", {31'h0, hit}, 32'h1);
    @(posedge CLK); #2;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h2000_0103;
    restart(32'h2000_0100);
    @(posedge CLK); #2;
    REDIRECT = 1'b0;
    @(negedge CLK);
    check("redir_ivalid_low", {31'h0, I_VALID}, 32'h0);
    check("redir_memwait", {31'h0, MEM_WAIT}, 32'h1);
    check("redir_err_clear", {31'h0, FETCH_ERR}, 32'h0);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (I_VALID) hit = 1'b1;
      else @(negedge CLK);
    end
    check("redir_valid_seen", {31'h0, hit}, 32'h1);
    check("redir_first_pc", I_PC, 32'h2000_0100);
    repeat (20) @(posedge CLK);

    // Redirect landing on a cycle with both an AR handshake and an R beat.
    err_addr = 32'h1;
    lat_min = 0; lat_max = 1; ardy_pct = 60;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge CLK); #2;
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY && axi.M_AXI_RVALID) begin
        REDIRECT = 1'b1; REDIRECT_PC = 32'h2000_0200;
        restart(32'h2000_0200);
        hit = 1'b1;
        @(posedge CLK); #2;
        REDIRECT = 1'b0;
      end
    end
    check("ar_r_redirect_hit", {31'h0, hit}, 32'h1);
    repeat (30) @(posedge CLK);

    // Randomized traffic with stalls, pauses, redirects and an occasional reset.
    lat_min = 0; lat_max = 4; ardy_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      int r;
      @(posedge CLK); #2;
      REDIRECT = 1'b0;
      STALL = ($urandom_range(99, 0) < 30);
      EXEC  = ($urandom_range(99, 0) < 85);
      if (RST) begin
        RST = 1'b0;
        restart(RESET_PC);
      end else begin
        r = int'($urandom_range(999, 0));
        if (r < 25) begin
          logic [31:0] t;
          t = 32'h2000_0000 + 32'($urandom_range(255, 0) * 4);
          REDIRECT = 1'b1;
          REDIRECT_PC = t | 32'($urandom_range(3, 0));
          restart(t);
        end else if (r == 500) begin
          RST = 1'b1;
        end
      end
    end

    @(posedge CLK); #2;
    REDIRECT = 1'b0; RST = 1'b0; EXEC = 1'b0; STALL = 1'b0;
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    check("drain_ivalid", {31'h0, I_VALID}, 32'h0);
    check("drain_memwait", {31'h0, MEM_WAIT}, 32'h0);
    check("final_err", {31'h0, FETCH_ERR}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
